copro_axil_slave: RTL and testbench

- AXI4-Lite responder for the copro S00_AXI port; the slave end of the master agent's write/read traffic.
- Holds NUM_REGS 32-bit read/write registers at word-aligned offsets 0x0, 0x4, 0x8, 0xC, ...
- Accepts AW and W independently and in either order. Returns B and R responses with fixed latency.
- Exports the raw register bank to the copro datapath.

---
 rtl/copro_axil_pkg.sv | 29 ++
 rtl/copro_axil_regbank.sv | 68 ++++++
 rtl/copro_axil_slave.sv | 170 +++++++++++++++++
 tb/tb_copro_axil_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/copro_axil_pkg.sv
// copro_axil_pkg
//   Shared types and helpers for the copro AXI4-Lite register slave.
//   - RESP_OKAY / RESP_SLVERR : AXI response codes
//   - word_t / strb_t          : 32-bit data word and 4-bit byte strobe
//   - hold_state_e             : per-channel hold state of the write path
//   - strb_merge()             : byte-wise merge of new data into an old word
package copro_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic {
        HOLD_IDLE = 1'b0,
        HOLD_HELD = 1'b1
    } hold_state_e;

    // Bytes whose strobe bit is set come from new_word, the rest keep old_word.
    function automatic word_t strb_merge(word_t old_word, word_t new_word, strb_t strb);
        word_t merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/copro_axil_regbank.sv
// copro_axil_regbank
//   Register storage for the copro AXI4-Lite slave.
//   Ports:
//     clk, rst_n      : clock, synchronous active-low reset (clears all registers)
//     wr_en           : commit strobe; merges wr_data into reg[wr_index] under wr_strb
//     wr_index        : word index of the write
//     wr_data/wr_strb : write data and byte enables
//     wr_in_range     : wr_index addresses an implemented register
//     rd_index        : word index of the read (combinational mux)
//     rd_data         : reg[rd_index], or 0 when out of range
//     rd_in_range     : rd_index addresses an implemented register
//     regs            : flat register bank, reg k at bits [32k+31:32k]
module copro_axil_regbank
    import copro_axil_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_index,
    input  word_t                 wr_data,
    input  strb_t                 wr_strb,
    output logic                  wr_in_range,
    input  logic [IDX_W-1:0]      rd_index,
    output word_t                 rd_data,
    output logic                  rd_in_range,
    output logic [NUM_REGS*32-1:0] regs
);

    word_t regs_q [NUM_REGS];

    assign wr_in_range = int'(wr_index) < NUM_REGS;
    assign rd_in_range = int'(rd_index) < NUM_REGS;

    // Out-of-range writes match no k and are silently dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_en && (wr_index == IDX_W'(k))) begin
                    regs_q[k] <= strb_merge(regs_q[k], wr_data, wr_strb);
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_index == IDX_W'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    always_comb begin
        regs = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs[32*k +: 32] = regs_q[k];
        end
    end

endmodule

// File: rtl/copro_axil_slave.sv
// copro_axil_slave
//   AXI4-Lite responder for the copro S00_AXI port. NUM_REGS 32-bit
//   read/write registers at word offsets 0x0, 0x4, ...; the raw bank is
//   exported on regs_o.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESETN : clock, synchronous active-low reset
//     S_AXI_AW*, S_AXI_W*       : write address / data channels (independent, any order)
//     S_AXI_B*                  : write response, BVALID two cycles after the last of AW/W
//     S_AXI_AR*, S_AXI_R*       : read address / data, RVALID one cycle after AR
//     regs_o                    : flat register bank, reg k at bits [32k+31:32k]
//   Build option:
//     COPRO_AXIL_SLVERR_EN : out-of-range accesses answer SLVERR instead of OKAY.
//
// Handshake rule on every channel: a beat transfers on a rising edge where
// both VALID and READY are high; a source holds VALID and its payload stable
// until that edge, and READY may be withdrawn at any time.
module copro_axil_slave
    import copro_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          regs_o
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    // Write-path state: each channel is either waiting for its beat or holding it.
    hold_state_e          aw_st;
    hold_state_e          w_st;
    logic [IDX_W-1:0]     aw_idx_q;
    word_t                w_data_q;
    strb_t                w_strb_q;
    logic                 bvalid_q;
    logic [1:0]           bresp_q;

    logic                 rvalid_q;
    logic [1:0]           rresp_q;
    word_t                rdata_q;

    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;
    logic                 commit;

    logic                 wr_in_range;
    logic                 rd_in_range;
    word_t                rd_data;
    logic [1:0]           wr_resp;
    logic [1:0]           rd_resp;

    // A pending B blocks both write channels so only one write is ever in flight.
    assign S_AXI_AWREADY = S_AXI_ARESETN && (aw_st == HOLD_IDLE) && !bvalid_q;
    assign S_AXI_WREADY  = S_AXI_ARESETN && (w_st == HOLD_IDLE) && !bvalid_q;
    assign S_AXI_ARREADY = S_AXI_ARESETN && !rvalid_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (aw_st == HOLD_HELD) && (w_st == HOLD_HELD);

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;

`ifdef COPRO_AXIL_SLVERR_EN
    assign wr_resp = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    logic unused_sink;
    assign unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
    logic unused_sink;
    assign unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           wr_in_range, rd_in_range};
`endif

    // Write FSM: capture AW and W independently, commit one cycle after both
    // are held, raise BVALID on the commit edge and hold it until BREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_st    <= HOLD_IDLE;
            w_st     <= HOLD_IDLE;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_st    <= HOLD_HELD;
                aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_st     <= HOLD_HELD;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_st    <= HOLD_IDLE;
                w_st     <= HOLD_IDLE;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read path: the mux output is sampled on the AR edge, so a write
    // committing on that same edge is not yet visible to the read.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
                rdata_q  <= rd_data;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    copro_axil_regbank #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_regbank (
        .clk         (S_AXI_ACLK),
        .rst_n       (S_AXI_ARESETN),
        .wr_en       (commit),
        .wr_index    (aw_idx_q),
        .wr_data     (w_data_q),
        .wr_strb     (w_strb_q),
        .wr_in_range (wr_in_range),
        .rd_index    (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .rd_data     (rd_data),
        .rd_in_range (rd_in_range),
        .regs        (regs_o)
    );

endmodule

// File: tb/tb_copro_axil_slave.sv
// tb_copro_axil_slave
//   Bench for copro_axil_slave: directed scenarios plus randomized traffic,
//   expected responses queued at issue time and checked by a monitor.
module tb_copro_axil_slave;

    localparam int AW  = 6;
    localparam int NR  = 4;
    localparam int TMO = 200;

    localparam int C_AW = 0;
    localparam int C_W  = 1;
    localparam int C_AR = 2;
    localparam int C_B  = 3;
    localparam int C_R  = 4;
    localparam int C_BV = 5;
    localparam int C_RV = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b1;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b1;
    logic [NR*32-1:0] regs_o;

    copro_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .regs_o        (regs_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];
    logic [31:0] model_regs [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: registers are a plain array indexed by byte address / 4.
    function automatic int idx_of(input logic [AW-1:0] addr);
        return int'(addr) / 4;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
        if (idx_of(addr) < NR) return 2'b00;
`ifdef COPRO_AXIL_SLVERR_EN
        return 2'b10;
`else
        return 2'b00;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
        if (idx_of(addr) < NR) return model_regs[idx_of(addr)];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = idx_of(addr);
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NR; k++) model_regs[k] = 32'h0;
    endtask

    task automatic check_regs(input string name);
        for (int k = 0; k < NR; k++) begin
            chk(name, 64'(regs_o[32*k +: 32]), 64'(model_regs[k]));
        end
    endtask

    // ---------------- monitor ----------------
    logic bvalid_prev = 1'b0;
    logic rvalid_prev = 1'b0;
    int   aw_cyc = 0;
    int   w_cyc  = 0;
    int   ar_cyc = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (awvalid && awready) aw_cyc = cyc;
            if (wvalid && wready)   w_cyc  = cyc;
            if (arvalid && arready) ar_cyc = cyc;
            if (bvalid && !bvalid_prev)
                chk("b_latency", 64'(cyc), 64'(((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 2));
            if (rvalid && !rvalid_prev)
                chk("r_latency", 64'(cyc), 64'(ar_cyc + 1));
            if (bvalid && bready) begin
                if (b_exp_q.size() == 0) chk("unexpected_b", 64'(1), 64'(0));
                else chk("bresp", 64'(bresp), 64'(b_exp_q.pop_front()));
            end
            if (rvalid && rready) begin
                if (r_exp_q.size() == 0) chk("unexpected_r", 64'(1), 64'(0));
                else chk("rresp_rdata", 64'({rresp, rdata}), 64'(r_exp_q.pop_front()));
            end
        end
        bvalid_prev = bvalid;
        rvalid_prev = rvalid;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cond(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < TMO && !hit; t++) begin
            @(negedge clk);
            case (which)
                C_AW:    hit = awready;
                C_W:     hit = wready;
                C_AR:    hit = arready;
                C_B:     hit = bvalid && bready;
                C_R:     hit = rvalid && rready;
                C_BV:    hit = bvalid;
                default: hit = rvalid;
            endcase
        end
        if (!hit) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay, input int w_delay,
                            input bit wait_b);
        b_exp_q.push_back(exp_resp(addr));
        model_write(addr, data, strb);
        fork
            begin
                repeat (aw_delay) step();
                awaddr  = addr;
                awvalid = 1'b1;
                wait_cond(C_AW, "aw");
                step();
                awvalid = 1'b0;
            end
            begin
                repeat (w_delay) step();
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
                wait_cond(C_W, "w");
                step();
                wvalid = 1'b0;
            end
        join
        if (wait_b) begin
            wait_cond(C_B, "b");
            step();
        end
    endtask

    task automatic do_read_raw(input logic [AW-1:0] addr, input int delay);
        rready  = (delay == 0);
        araddr  = addr;
        arvalid = 1'b1;
        wait_cond(C_AR, "ar");
        step();
        arvalid = 1'b0;
        if (delay > 0) begin
            wait_cond(C_RV, "rvalid");
            repeat (delay) step();
            rready = 1'b1;
        end
        wait_cond(C_R, "r");
        step();
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int delay);
        r_exp_q.push_back({exp_resp(addr), model_read(addr)});
        do_read_raw(addr, delay);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [33:0]   pre;

        model_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready",  64'(wready),  64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        step();
        rstn = 1'b1;
        @(negedge clk);
        check_regs("reset_regs");
        chk("reset_bvalid", 64'(bvalid), 64'(0));
        chk("reset_rvalid", 64'(rvalid), 64'(0));
        chk("reset_rdata",  64'({rresp, bresp, rdata}), 64'(0));
        chk("idle_readies", 64'({awready, wready, arready}), 64'(3'b111));
        step();

        // Sequential writes then read-back.
        for (int k = 0; k < NR; k++) do_write(AW'(4*k), 32'(k + 1), 4'hF, 0, 0, 1'b1);
        check_regs("seq_regs");
        for (int k = 0; k < NR; k++) do_read(AW'(4*k), 0);

        // W three cycles before AW.
        fork
            do_write(AW'(8), 32'hDEADBEEF, 4'hF, 3, 0, 1'b1);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("w_early_wready", 64'({wready, awvalid}), 64'(0));
            end
        join
        do_read(AW'(8), 1);

        // Byte-strobe merge.
        do_write(AW'(0), 32'h11223344, 4'hF, 0, 0, 1'b1);
        do_write(AW'(0), 32'hAABBCCDD, 4'b0101, 1, 0, 1'b1);
        chk("strb_merge_reg0", 64'(regs_o[31:0]), 64'(32'h11BB33DD));
        do_read(AW'(0), 0);

        // WSTRB = 0 is a no-op write that still responds.
        do_write(AW'(4), 32'hFFFFFFFF, 4'h0, 0, 0, 1'b1);
        check_regs("strb0_regs");

        // BREADY held low: write channel stalls behind the pending B.
        bready = 1'b0;
        do_write(AW'(12), 32'h0BADF00D, 4'hF, 0, 0, 1'b0);
        wait_cond(C_BV, "bp_bvalid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({bvalid, awready, wready}), 64'(3'b100));
        end
        step();
        fork
            do_write(AW'(4), 32'h55AA55AA, 4'hF, 0, 0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_second_blocked", 64'({awready, wready}), 64'(0));
                end
                step();
                bready = 1'b1;
            end
        join
        check_regs("bp_regs");

        // Out-of-range access.
        do_write(AW'(6'h20), 32'h12345678, 4'hF, 0, 1, 1'b1);
        check_regs("oor_regs");
        do_read(AW'(6'h20), 0);

        // Read sampled on the same edge as a write commit sees the old value.
        pre = {exp_resp(AW'(8)), model_read(AW'(8))};
        r_exp_q.push_back(pre);
        fork
            do_write(AW'(8), 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);
            begin
                step();
                do_read_raw(AW'(8), 0);
            end
        join
        do_read(AW'(8), 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(0, (NR + 2) * 4 - 1));
            d = $urandom;
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            check_regs("rand_regs");
            if ($urandom_range(0, 1) == 1)
                do_read(AW'($urandom_range(0, (NR + 2) * 4 - 1)), $urandom_range(0, 2));
        end

        // Reset mid-transaction: AW held and an R pending.
        awaddr  = AW'(4);
        awvalid = 1'b1;
        wait_cond(C_AW, "rst_aw");
        step();
        awvalid = 1'b0;
        rready  = 1'b0;
        araddr  = AW'(0);
        arvalid = 1'b1;
        wait_cond(C_AR, "rst_ar");
        step();
        arvalid = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        r_exp_q.delete();
        model_reset();
        rready = 1'b1;
        @(negedge clk);
        check_regs("midrst_regs");
        for (int i = 0; i < 10; i++) begin
            chk("midrst_no_resp", 64'({bvalid, rvalid}), 64'(0));
            @(negedge clk);
        end
        step();
        do_write(AW'(12), 32'h13579BDF, 4'hF, 0, 2, 1'b1);
        check_regs("post_rst_regs");
        do_read(AW'(4), 0);
        do_read(AW'(12), 0);

        repeat (5) step();
        chk("b_queue_drained", 64'(b_exp_q.size()), 64'(0));
        chk("r_queue_drained", 64'(r_exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
